// File: rtl/map_mem_pkg.sv
// Shared types and default sizing for the maze-map port-A arbiter.
package map_mem_pkg;

  localparam int MAP_NUM_REQ      = 3;
  localparam int MAP_DATA_WIDTH   = 4;
  localparam int MAP_DATA_DEPTH   = 1023;
  localparam int MAP_READ_LATENCY = 1;
  localparam int MAP_AW           = $clog2(MAP_DATA_DEPTH);
  localparam int MAP_DW           = MAP_DATA_WIDTH;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB  = 2'd0;
  localparam arb_state_t KICK = 2'd1;
  localparam arb_state_t WAIT = 2'd2;

  typedef logic [$clog2(MAP_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/map_mem_arbiter_rr_arbiter.sv
// Round-robin grant: first valid requester at or after the pointer, circular order.
module rr_arbiter
  import map_mem_pkg::*;
#(
  parameter int N = MAP_NUM_REQ,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          soft_rst,
  input  logic [N-1:0]  valid,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_reg, ptr_next;

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    ptr_next  = ptr_reg;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(ptr_reg) + off) % N);
      if (enable && !found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        ptr_next    = IW'((int'(cand) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/map_mem_arbiter.sv
// Shares maze-map BRAM port A among game-logic requesters and sequences level restores.
module map_mem_arbiter
  import map_mem_pkg::*;
#(
  parameter int NUM_REQ      = MAP_NUM_REQ,
  parameter int DATA_WIDTH   = MAP_DATA_WIDTH,
  parameter int DATA_DEPTH   = MAP_DATA_DEPTH,
  parameter int READ_LATENCY = MAP_READ_LATENCY,
  localparam int AW = $clog2(DATA_DEPTH),
  localparam int DW = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  soft_rst,
  input  logic                  level_restart,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  busy,
  output logic                  bram_rst,
  output logic                  bram_wea,
  output logic [AW-1:0]         bram_addra,
  output logic [DW-1:0]         bram_dia,
  input  logic [DW-1:0]         bram_douta
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t           state_reg, state_next;
  logic [AW-1:0]        cnt_reg, cnt_next;
  logic                 arb_en;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        grant_idx;
  logic [AW-1:0]        addr_arr  [NUM_REQ];
  logic [DW-1:0]        wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   tag_pipe_reg [READ_LATENCY];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
  end

  // A restart request takes priority over any grant in the same cycle.
  assign arb_en = !soft_rst && (state_reg == ARB) && !level_restart;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .soft_rst  (soft_rst),
    .valid     (req_valid),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ARB:  if (level_restart) state_next = KICK;
      KICK: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
      WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == AW'(DATA_DEPTH - 1)) state_next = ARB;
      end
      default: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_reg <= WAIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    bram_wea   = 1'b0;
    bram_addra = '0;
    bram_dia   = '0;
    if (|grant) begin
      bram_wea   = req_we[grant_idx];
      bram_addra = addr_arr[grant_idx];
      bram_dia   = wdata_arr[grant_idx];
    end
  end

  // One-hot read tags travel alongside the BRAM read latency.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_pipe_reg[i] <= '0;
    end else begin
      tag_pipe_reg[0] <= grant & ~req_we;
      for (int i = 1; i < READ_LATENCY; i++) tag_pipe_reg[i] <= tag_pipe_reg[i-1];
    end
  end

  assign req_ready = grant;
  assign rsp_valid = soft_rst ? '0 : tag_pipe_reg[READ_LATENCY-1];
  assign rsp_rdata = (|rsp_valid) ? bram_douta : '0;
  assign busy      = soft_rst || (state_reg != ARB);
  assign bram_rst  = soft_rst || (state_reg == KICK);

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Randomised scoreboard bench for map_mem_arbiter against a restorable-BRAM model.
module tb_map_mem_arbiter;

  localparam int N     = map_mem_pkg::MAP_NUM_REQ;
  localparam int DW    = map_mem_pkg::MAP_DATA_WIDTH;
  localparam int DEPTH = map_mem_pkg::MAP_DATA_DEPTH;
  localparam int RL    = map_mem_pkg::MAP_READ_LATENCY;
  localparam int AW    = $clog2(DEPTH);
  localparam int MSZ   = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            soft_rst, level_restart;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, bram_dia, bram_douta;
  logic            busy, bram_rst, bram_wea;
  logic [AW-1:0]   bram_addra;

  map_mem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .soft_rst(soft_rst), .level_restart(level_restart),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .bram_rst(bram_rst), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dia(bram_dia),
    .bram_douta(bram_douta)
  );

  function automatic logic [DW-1:0] init_val(int a);
    return DW'((a * 3 + 4) & 15);
  endfunction

  // Restorable BRAM port A, one-cycle registered read.
  logic [DW-1:0] bram_mem [MSZ];
  always @(posedge clk) begin
    if (bram_rst) begin
      for (int a = 0; a < MSZ; a++) bram_mem[a] <= init_val(a);
    end else if (bram_wea) begin
      bram_mem[bram_addra] <= bram_dia;
    end
    bram_douta <= bram_mem[bram_addra];
  end

  typedef struct { int tag; logic [DW-1:0] data; int due; } rsp_t;
  rsp_t rq[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference state: remaining busy cycles, pending kick, round-robin start, memory image.
  logic [DW-1:0] ref_mem [MSZ];
  int ptr_m = 0, wait_left = DEPTH, last_gnt = -1;
  bit kick_m = 0;
  logic         v [N];
  logic         we_a [N];
  logic [AW-1:0] ad [N];
  logic [DW-1:0] wd [N];

  task automatic restore_ref();
    for (int a = 0; a < MSZ; a++) ref_mem[a] = init_val(a);
  endtask

  task automatic set_req(int i, logic vv, logic w, int a, int d);
    v[i] = vv; we_a[i] = w; ad[i] = AW'(a); wd[i] = DW'(d);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic tick();
    int g;
    logic exp_busy, exp_rst, exp_wea;
    logic [N-1:0] exp_ready;
    rsp_t e;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_we[i] = we_a[i];
      req_addr[i*AW +: AW] = ad[i];
      req_wdata[i*DW +: DW] = wd[i];
    end
    @(negedge clk);
    g = -1; exp_busy = 1'b1; exp_rst = 1'b0; exp_wea = 1'b0;
    if (soft_rst || kick_m) exp_rst = 1'b1;
    else if (wait_left == 0) begin
      exp_busy = 1'b0;
      if (!level_restart) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (ptr_m + k) % N;
          if (g < 0 && v[c]) g = c;
        end
      end
    end
    exp_ready = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      exp_wea = we_a[g];
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("bram_rst", 32'(bram_rst), 32'(exp_rst));
    chk("bram_wea", 32'(bram_wea), 32'(exp_wea));
    if (g >= 0) begin
      chk("bram_addra", 32'(bram_addra), 32'(ad[g]));
      chk("bram_dia", 32'(bram_dia), 32'(wd[g]));
    end
    if (soft_rst) begin
      chk("rst_addra", 32'(bram_addra), 0);
      chk("rst_dia", 32'(bram_dia), 0);
      chk("rst_rdata", 32'(rsp_rdata), 0);
    end
    if (g >= 0) begin
      if (we_a[g]) ref_mem[ad[g]] = wd[g];
      else begin
        e.tag = g; e.data = ref_mem[ad[g]]; e.due = cyc + RL;
        rq.push_back(e);
      end
      ptr_m = (g + 1) % N;
    end
    if (soft_rst) begin
      ptr_m = 0; kick_m = 0; wait_left = DEPTH; restore_ref();
    end else if (kick_m) begin
      kick_m = 0; wait_left = DEPTH; restore_ref();
    end else if (wait_left > 0) begin
      wait_left--;
    end else if (level_restart) begin
      kick_m = 1;
    end
    last_gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_granted(int i, int budget);
    bit got;
    got = 0;
    for (int t = 0; t < budget && !got; t++) begin
      tick();
      if (last_gnt == i) got = 1;
    end
    if (!got) chk("grant_timeout", 0, 1);
    v[i] = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    rsp_t e;
    if (soft_rst) begin
      rq.delete();
      chk("rsp_flush", 32'(rsp_valid), 0);
    end else if (rsp_valid != '0) begin
      if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        e = rq.pop_front();
        $display("rsp cycle %0d: req%0d data %0h (expect req%0d data %0h)", cyc, $clog2(rsp_valid), rsp_rdata, e.tag, e.data);
        chk("rsp_tag", 32'(rsp_valid), 32'(1) << e.tag);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
        chk("rsp_time", cyc, e.due);
      end
    end else if (rq.size() != 0 && rq[0].due <= cyc) begin
      e = rq.pop_front();
      chk("rsp_missing", 0, 32'(1) << e.tag);
    end
  end

  initial begin
    soft_rst = 1'b1;
    level_restart = 1'b0;
    clear_all();
    restore_ref();
    tick();
    soft_rst = 1'b0;

    // All three requesters held valid through the restore: grants 0,1,2,0,1,2.
    set_req(0, 1'b1, 1'b0, 0, 0);
    set_req(1, 1'b1, 1'b0, 5, 0);
    set_req(2, 1'b1, 1'b0, 7, 0);
    repeat (DEPTH + 6) tick();

    clear_all();
    tick();
    set_req(0, 1'b1, 1'b1, 12, 'hA);
    wait_granted(0, 8);
    set_req(2, 1'b1, 1'b0, 12, 0);
    wait_granted(2, 8);
    repeat (3) tick();

    // Restart colliding with a request, then a restart pulse inside WAIT.
    set_req(0, 1'b1, 1'b0, 12, 0);
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
    repeat (5) tick();
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
    wait_granted(0, DEPTH + 10);
    repeat (3) tick();

    // Reset right after a read grant flushes its response; reset inside WAIT restarts the sweep.
    set_req(1, 1'b1, 1'b0, 5, 0);
    wait_granted(1, 8);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    repeat (100) tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    set_req(2, 1'b1, 1'b0, 12, 0);
    wait_granted(2, DEPTH + 10);

    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (last_gnt == i || !v[i]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)));
          else v[i] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          v[i] = 1'b0;
        end
      end
      level_restart = ($urandom_range(0, 799) == 0);
      tick();
    end
    level_restart = 1'b0;
    clear_all();
    repeat (4) tick();
    chk("rsp_queue_empty", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
